// File: rtl/mem_word_loader_pkg.sv
// Shared memory geometry, loader FSM states and the load range check.
// Imported by the word loader and by anything sharing the byte memory.
package mem_word_loader_pkg;

    localparam int MEM_DEPTH  = 2048;
    localparam int MEM_WIDTH  = 8;
    localparam int WORD_WIDTH = 2 * MEM_WIDTH;
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);

    // Depth widened by two bits so base + 2*count never wraps.
    localparam logic [ADDR_WIDTH+1:0] DEPTH_X = (ADDR_WIDTH + 2)'(MEM_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WAIT_WORD,
        ST_WR_HI,
        ST_WR_LO,
        ST_FIN
    } state_e;

    // A load is rejected if it starts on an odd byte or runs past the end.
    function automatic logic load_bad(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [ADDR_WIDTH-1:0] cnt
    );
        logic [ADDR_WIDTH+1:0] end_x;
        end_x = {2'b00, base} + {1'b0, cnt, 1'b0};
        return base[0] || (end_x > DEPTH_X);
    endfunction

endpackage

// File: rtl/mem_word_loader.sv
// Word loader: streams 16-bit words into byte memory, high byte first,
// and holds the CPU in reset until a load finishes without error.
module mem_word_loader
    import mem_word_loader_pkg::*;
(
    input  logic                  clock,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_word,
    output logic                  in_ready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_WIDTH-1:0]  mem_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cpu_nrst
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic                  in_ready_q, in_ready_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MEM_WIDTH-1:0]  data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  cpu_nrst_q, cpu_nrst_d;

    // State and registered outputs; reset drops everything to idle.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            count_q    <= '0;
            word_q     <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_nrst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            word_q     <= word_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cpu_nrst_q <= cpu_nrst_d;
        end
    end

    // Next state plus next output values, so every output is a flop.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        word_d     = word_q;
        in_ready_d = 1'b0;
        wr_en_d    = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        cpu_nrst_d = cpu_nrst_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_d      = base_addr;
                    count_d    = word_count;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    cpu_nrst_d = 1'b0;
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (load_bad(ptr_q, count_q)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end else if (count_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    in_ready_d = 1'b1;
                    state_d    = ST_WAIT_WORD;
                end
            end
            ST_WAIT_WORD: begin
                if (in_valid && in_ready_q) begin
                    word_d  = in_word;
                    wr_en_d = 1'b1;
                    addr_d  = ptr_q;
                    data_d  = in_word[WORD_WIDTH-1 -: MEM_WIDTH];
                    state_d = ST_WR_HI;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_WR_HI: begin
                wr_en_d = 1'b1;
                addr_d  = ptr_q + ADDR_WIDTH'(1);
                data_d  = word_q[MEM_WIDTH-1:0];
                state_d = ST_WR_LO;
            end
            ST_WR_LO: begin
                count_d = count_q - ADDR_WIDTH'(1);
                if (count_q == ADDR_WIDTH'(1)) begin
                    done_d  = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    ptr_d      = ptr_q + ADDR_WIDTH'(2);
                    in_ready_d = 1'b1;
                    state_d    = ST_WAIT_WORD;
                end
            end
            ST_FIN: begin
                busy_d     = 1'b0;
                cpu_nrst_d = ~err_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready    = in_ready_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign cpu_nrst    = cpu_nrst_q;

endmodule

// File: tb/tb_mem_word_loader.sv
// Bench for mem_word_loader: random word streams against a byte-image
// model of the memory, plus the fixed corner loads and a mid-load reset.
`timescale 1ns/1ps
module tb_mem_word_loader;

    localparam int DEPTH = 2048;

    logic        clock = 1'b0;
    logic        nrst  = 1'b1;
    logic        start = 1'b0;
    logic [10:0] base_addr  = '0;
    logic [10:0] word_count = '0;
    logic        in_valid = 1'b0;
    logic [15:0] in_word  = '0;
    logic        in_ready;
    logic        mem_wr_en;
    logic [10:0] mem_addr;
    logic [7:0]  mem_wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_nrst;

    mem_word_loader dut (
        .clock       (clock),
        .nrst        (nrst),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .in_valid    (in_valid),
        .in_word     (in_word),
        .in_ready    (in_ready),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .cpu_nrst    (cpu_nrst)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory seen by the DUT: a strobe sampled mid-cycle lands at the next
    // rising edge unless reset is held at that edge.
    logic [7:0]  dmem [DEPTH];
    int          strobes = 0;
    int          dones   = 0;
    logic        pend_en = 1'b0;
    logic [10:0] pend_a  = '0;
    logic [7:0]  pend_d  = '0;

    always @(negedge clock) begin
        pend_en = (mem_wr_en === 1'b1);
        pend_a  = mem_addr;
        pend_d  = mem_wr_data;
        if (done === 1'b1) dones++;
    end

    always @(posedge clock) begin
        if (pend_en && nrst) begin
            dmem[pend_a] = pend_d;
            strobes++;
        end
    end

    // Reference image: what memory should hold after every load so far.
    logic [7:0]  rmem   [DEPTH];
    bit          rvalid [DEPTH];
    logic [15:0] preset [$];

    task automatic run_load(input logic [10:0] b, input logic [10:0] c,
                            input int gmin, input int gmax,
                            input bit poke, input int abort_word);
        logic [15:0] w [$];
        int s0, d0, idx, gap, cyc;
        bit hs, exp_err;
        exp_err = b[0] || (int'(b) + 2 * int'(c) > DEPTH);
        if (preset.size() > 0) begin
            w = preset;
            preset.delete();
        end else begin
            for (int i = 0; i < int'(c) && i < 64; i++)
                w.push_back(16'($urandom));
        end
        s0 = strobes;
        d0 = dones;
        @(negedge clock);
        start = 1'b1;
        base_addr = b;
        word_count = c;
        @(negedge clock);
        start = 1'b0;
        base_addr = 11'($urandom);
        word_count = 11'($urandom);
        idx = 0;
        gap = $urandom_range(gmax, gmin);
        cyc = 1;
        while (cyc < 3000) begin
            if (done === 1'b1) break;
            if (cyc == 1) begin
                chk("busy_during", 32'(busy), 1);
                chk("cpu_held", 32'(cpu_nrst), 0);
            end
            if (mem_wr_en === 1'b1)
                chk("ready_in_write", 32'(in_ready), 0);
            if (abort_word >= 0 && mem_wr_en === 1'b1 &&
                mem_addr == b + 11'(2 * abort_word)) begin
                #2 nrst = 1'b0;
                #1;
                chk("rst_wr_en", 32'(mem_wr_en), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_ready", 32'(in_ready), 0);
                chk("rst_cpu", 32'(cpu_nrst), 0);
                chk("rst_addr", 32'(mem_addr), 0);
                in_valid = 1'b0;
                for (int i = 0; i < abort_word; i++) begin
                    rmem[b + 11'(2 * i)]     = w[i][15:8];
                    rmem[b + 11'(2 * i + 1)] = w[i][7:0];
                    rvalid[b + 11'(2 * i)]     = 1'b1;
                    rvalid[b + 11'(2 * i + 1)] = 1'b1;
                end
                @(negedge clock);
                chk("abort_strobes", 32'(strobes - s0), 32'(2 * abort_word));
                nrst = 1'b1;
                return;
            end
            start = 1'b0;
            if (poke && cyc == 4) begin
                start = 1'b1;
                base_addr = 11'h400;
                word_count = 11'd1;
            end
            if (gap > 0) begin
                in_valid = 1'b0;
                gap--;
            end else if (idx < w.size()) begin
                in_valid = 1'b1;
                in_word = w[idx];
            end else begin
                in_valid = 1'b0;
            end
            hs = in_valid && (in_ready === 1'b1);
            @(negedge clock);
            cyc++;
            if (hs) begin
                idx++;
                gap = $urandom_range(gmax, gmin);
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
        chk("done_seen", 32'(done), 1);
        if (exp_err || c == 0) chk("done_latency", 32'(cyc), 2);
        @(negedge clock);
        chk("done_pulse", 32'(done), 0);
        chk("done_once", 32'(dones - d0), 1);
        chk("busy_end", 32'(busy), 0);
        chk("err", 32'(err), 32'(exp_err));
        chk("cpu_nrst", 32'(cpu_nrst), 32'(!exp_err));
        chk("strobes", 32'(strobes - s0), exp_err ? 0 : 32'(2 * int'(c)));
        chk("accepted", 32'(idx), exp_err ? 0 : 32'(c));
        if (!exp_err) begin
            for (int i = 0; i < int'(c); i++) begin
                rmem[b + 11'(2 * i)]     = w[i][15:8];
                rmem[b + 11'(2 * i + 1)] = w[i][7:0];
                rvalid[b + 11'(2 * i)]     = 1'b1;
                rvalid[b + 11'(2 * i + 1)] = 1'b1;
                chk("byte_hi", 32'(dmem[b + 11'(2 * i)]), 32'(w[i][15:8]));
                chk("byte_lo", 32'(dmem[b + 11'(2 * i + 1)]), 32'(w[i][7:0]));
            end
        end
    endtask

    initial begin
        int diffs;
        int c;
        int b;
        for (int a = 0; a < DEPTH; a++) begin
            rmem[a] = '0;
            rvalid[a] = 1'b0;
        end
        #5 nrst = 1'b0;
        #15;
        chk("reset_ready", 32'(in_ready), 0);
        chk("reset_wr_en", 32'(mem_wr_en), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_cpu", 32'(cpu_nrst), 0);
        chk("reset_addr", 32'(mem_addr), 0);
        chk("reset_data", 32'(mem_wr_data), 0);
        #10 nrst = 1'b1;

        preset = '{16'h1234, 16'hABCD, 16'h00FF};
        run_load(11'h000, 11'd3, 0, 0, 1'b0, -1);
        chk("fix_b0", 32'(dmem[0]), 32'h12);
        chk("fix_b1", 32'(dmem[1]), 32'h34);
        chk("fix_b2", 32'(dmem[2]), 32'hAB);
        chk("fix_b3", 32'(dmem[3]), 32'hCD);
        chk("fix_b4", 32'(dmem[4]), 32'h00);
        chk("fix_b5", 32'(dmem[5]), 32'hFF);

        run_load(11'h010, 11'd2, 5, 5, 1'b0, -1);
        run_load(11'h7FC, 11'd2, 0, 2, 1'b0, -1);
        run_load(11'h7FE, 11'd2, 0, 2, 1'b0, -1);
        run_load(11'h003, 11'd1, 0, 2, 1'b0, -1);
        run_load(11'h020, 11'd0, 0, 2, 1'b0, -1);

        run_load(11'h100, 11'd3, 0, 1, 1'b0, 1);
        run_load(11'h100, 11'd3, 0, 2, 1'b1, -1);

        for (int k = 0; k < 8; k++) begin
            c = $urandom_range(16, 1);
            b = 2 * $urandom_range((DEPTH - 2 * c) / 2, 0);
            run_load(11'(b), 11'(c), 0, 3, 1'b0, -1);
        end
        run_load(11'($urandom_range(2047, 0) | 1), 11'd2, 0, 1, 1'b0, -1);
        run_load(11'h7F0, 11'($urandom_range(2047, 9)), 0, 1, 1'b0, -1);
        run_load(11'h200, 11'd4, 0, 0, 1'b0, -1);

        diffs = 0;
        for (int a = 0; a < DEPTH; a++)
            if (rvalid[a] && dmem[a] !== rmem[a]) diffs++;
        chk("mem_sweep", 32'(diffs), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
